// File: rtl/pix_pack_8x_if.sv
// Pixel-stream input and packed-word output bundle for pix_pack_8x.
interface pix_pack_8x_if #(
  parameter int unsigned DWIDTH = 10,
  parameter int unsigned PIXCNT = 8
);
  logic [DWIDTH-1:0]        pix_in;
  logic                     pix_vld;
  logic                     pix_sof;
  logic                     pix_eol;
  logic [DWIDTH*PIXCNT-1:0] data_out;
  logic                     out_vld;

  modport master (
    output pix_in, pix_vld, pix_sof, pix_eol,
    input  data_out, out_vld
  );

  modport slave (
    input  pix_in, pix_vld, pix_sof, pix_eol,
    output data_out, out_vld
  );
endinterface

// File: rtl/pix_pack_8x.sv
// Packs a 1-pixel/clk raster stream into PIXCNT-pixel words, pulses new_frame,
// measures frame geometry and flags malformed lines.
module pix_pack_8x #(
  parameter int unsigned DWIDTH = 10,
  parameter int unsigned PIXCNT = 8,
  parameter int unsigned ROWS   = 2049,
  parameter int unsigned COLS   = 2448
) (
  input  logic                     clk,
  input  logic                     rst,
  pix_pack_8x_if.slave             bus,
  output logic                     new_frame,
  output logic [$clog2(ROWS)-1:0]  rows,
  output logic [$clog2(COLS)-1:0]  cols,
  output logic                     err_pad,
  output logic                     err_len,
  output logic                     err_sof
);
  localparam int unsigned WW = DWIDTH * PIXCNT;
  localparam int unsigned LW = $clog2(PIXCNT);
  localparam int unsigned RW = $clog2(ROWS);
  localparam int unsigned CW = $clog2(COLS);

  typedef enum logic [1:0] {IDLE, LINE, GAP} state_t;

  state_t         state_q, state_d;
  logic [LW-1:0]  lane_q, lane_d;
  logic [WW-1:0]  buf_q, buf_d;
  logic [CW-1:0]  pix_cnt_q, pix_cnt_d;
  logic [RW-1:0]  line_cnt_q, line_cnt_d;
  logic [CW-1:0]  first_len_q, first_len_d;
  logic [WW-1:0]  data_q, data_d;
  logic           out_vld_q, out_vld_d;
  logic           new_frame_d;
  logic [RW-1:0]  rows_d;
  logic [CW-1:0]  cols_d;
  logic           err_pad_d, err_len_d, err_sof_d;

  logic           start, take;
  logic [LW-1:0]  eff_lane;
  logic [WW-1:0]  word;
  logic [CW-1:0]  cur_pix, cur_first, len;
  logic [RW-1:0]  cur_line;

  assign bus.data_out = data_q;
  assign bus.out_vld  = out_vld_q;

  // Next-state, packing and geometry bookkeeping
  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    buf_d       = buf_q;
    pix_cnt_d   = pix_cnt_q;
    line_cnt_d  = line_cnt_q;
    first_len_d = first_len_q;
    data_d      = data_q;
    out_vld_d   = 1'b0;
    new_frame_d = 1'b0;
    rows_d      = rows;
    cols_d      = cols;
    err_pad_d   = err_pad;
    err_len_d   = err_len;
    err_sof_d   = err_sof;
    eff_lane    = lane_q;
    word        = '0;
    cur_pix     = pix_cnt_q;
    cur_line    = line_cnt_q;
    cur_first   = first_len_q;
    len         = '0;

    start = bus.pix_vld && bus.pix_sof;
    take  = bus.pix_vld && (bus.pix_sof || (state_q != IDLE));

    // A sof discards any partial word and restarts all per-frame state
    if (start) begin
      eff_lane    = LW'(PIXCNT - 1);
      new_frame_d = 1'b1;
      if (line_cnt_q != '0) begin
        rows_d = line_cnt_q;
        cols_d = first_len_q;
      end
      err_pad_d = 1'b0;
      err_len_d = 1'b0;
      err_sof_d = (state_q == LINE);
      cur_pix   = '0;
      cur_line  = '0;
      cur_first = '0;
    end

    if (take) begin
      // Lanes above the current one hold earlier pixels; the rest replicate this one
      for (int i = 0; i < int'(PIXCNT); i++) begin
        if (LW'(i) > eff_lane) word[i*DWIDTH +: DWIDTH] = buf_q[i*DWIDTH +: DWIDTH];
        else                   word[i*DWIDTH +: DWIDTH] = bus.pix_in;
      end
      buf_d       = word;
      len         = (cur_pix == {CW{1'b1}}) ? cur_pix : cur_pix + CW'(1);
      pix_cnt_d   = len;
      line_cnt_d  = cur_line;
      first_len_d = cur_first;
      state_d     = LINE;

      if ((eff_lane == '0) || bus.pix_eol) begin
        data_d    = word;
        out_vld_d = 1'b1;
        lane_d    = LW'(PIXCNT - 1);
      end else begin
        lane_d    = eff_lane - LW'(1);
      end

      if (bus.pix_eol) begin
        err_pad_d  = err_pad_d | (eff_lane != '0);
        line_cnt_d = (cur_line == {RW{1'b1}}) ? cur_line : cur_line + RW'(1);
        if (cur_line == '0)        first_len_d = len;
        else if (len != cur_first) err_len_d   = 1'b1;
        pix_cnt_d = '0;
        state_d   = GAP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lane_q      <= LW'(PIXCNT - 1);
      buf_q       <= '0;
      pix_cnt_q   <= '0;
      line_cnt_q  <= '0;
      first_len_q <= '0;
      data_q      <= '0;
      out_vld_q   <= 1'b0;
      new_frame   <= 1'b0;
      rows        <= RW'(ROWS);
      cols        <= CW'(COLS);
      err_pad     <= 1'b0;
      err_len     <= 1'b0;
      err_sof     <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      buf_q       <= buf_d;
      pix_cnt_q   <= pix_cnt_d;
      line_cnt_q  <= line_cnt_d;
      first_len_q <= first_len_d;
      data_q      <= data_d;
      out_vld_q   <= out_vld_d;
      new_frame   <= new_frame_d;
      rows        <= rows_d;
      cols        <= cols_d;
      err_pad     <= err_pad_d;
      err_len     <= err_len_d;
      err_sof     <= err_sof_d;
    end
  end
endmodule

// File: tb/tb_pix_pack_8x.sv
// Directed bench for pix_pack_8x: expected words are queued at stimulus time
// and a monitor checks every out_vld against the queue.
`timescale 1ns/1ps
module tb_pix_pack_8x;
  localparam int unsigned DW = 10;
  localparam int unsigned PC = 8;
  localparam int unsigned WW = DW * PC;

  typedef logic [WW-1:0] word_t;

  logic clk = 1'b0;
  logic rst;
  logic new_frame;
  logic [11:0] rows;
  logic [11:0] cols;
  logic err_pad, err_len, err_sof;

  pix_pack_8x_if #(.DWIDTH(DW), .PIXCNT(PC)) bus ();

  pix_pack_8x #(.DWIDTH(DW), .PIXCNT(PC), .ROWS(2049), .COLS(2448)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .new_frame (new_frame),
    .rows      (rows),
    .cols      (cols),
    .err_pad   (err_pad),
    .err_len   (err_len),
    .err_sof   (err_sof)
  );

  always #5 clk = ~clk;

  word_t exp_q[$];
  int n_cmp   = 0;
  int n_err   = 0;
  int n_exp   = 0;
  int n_words = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Hand-derived word: pixels first..last from lane 7 down, last value repeated into unused lanes
  function automatic word_t mk_word(input int first, input int last);
    word_t w;
    int v;
    w = '0;
    for (int k = PC - 1; k >= 0; k--) begin
      v = first + (int'(PC) - 1 - k);
      if (v > last) v = last;
      w[k*DW +: DW] = DW'(v);
    end
    return w;
  endfunction

  task automatic drive(input int v, input bit s, input bit e);
    @(negedge clk);
    bus.pix_in  = DW'(v);
    bus.pix_vld = 1'b1;
    bus.pix_sof = s;
    bus.pix_eol = e;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.pix_vld = 1'b0;
      bus.pix_sof = 1'b0;
      bus.pix_eol = 1'b0;
    end
  endtask

  // One line of consecutive values; with s set, checks the frame-start outputs right after the sof pixel
  task automatic send_line(input int base, input int len, input bit s, input bit e, input bit gap,
                           input int er, input int ec, input bit esof, input bit epad);
    for (int i = 0; i < len; i++) begin
      bit last;
      int ws;
      last = e && (i == len - 1);
      drive(base + i, s && (i == 0), last);
      if (last || ((i % PC) == PC - 1)) begin
        ws = i - (i % PC);
        exp_q.push_back(mk_word(base + ws, base + i));
        n_exp++;
      end
      if (s && (i == 0)) begin
        @(posedge clk); #1;
        check("sof_new_frame", new_frame, 1);
        check("sof_rows", rows, er);
        check("sof_cols", cols, ec);
        check("sof_err_sof", err_sof, esof);
        check("sof_err_pad", err_pad, epad);
        check("sof_err_len", err_len, 0);
      end
      if (gap) idle(1);
    end
  endtask

  task automatic flags(input string tag, input bit epad, input bit elen, input bit esof);
    @(posedge clk); #1;
    check({tag, "_new_frame"}, new_frame, 0);
    check({tag, "_err_pad"}, err_pad, epad);
    check({tag, "_err_len"}, err_len, elen);
    check({tag, "_err_sof"}, err_sof, esof);
  endtask

  task automatic frame16x3(input bit s, input bit gap, input int er, input int ec);
    send_line(0, 16, s, 1, gap, er, ec, 0, 0);
    send_line(16, 16, 0, 1, gap, 0, 0, 0, 0);
    send_line(32, 16, 0, 1, gap, 0, 0, 0, 0);
  endtask

  // Scoreboard monitor
  initial begin
    word_t e;
    forever begin
      @(posedge clk); #1;
      if (bus.out_vld === 1'b1) begin
        n_cmp++;
        n_words++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL word_unexpected: got %h expected none at %0t", bus.data_out, $time);
        end else begin
          e = exp_q.pop_front();
          if (bus.data_out !== e) begin
            n_err++;
            $display("FAIL word_data: got %h expected %h at %0t", bus.data_out, e, $time);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    bus.pix_in  = '0;
    bus.pix_vld = 1'b0;
    bus.pix_sof = 1'b0;
    bus.pix_eol = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data_out", 32'(bus.data_out), 0);
    check("rst_out_vld", bus.out_vld, 0);
    check("rst_new_frame", new_frame, 0);
    check("rst_rows", rows, 2049);
    check("rst_cols", cols, 2448);
    check("rst_errs", {err_pad, err_len, err_sof}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Contiguous 16x3 frame, then the same frame with a gap after every pixel
    frame16x3(1, 0, 2049, 2448);
    flags("f1", 0, 0, 0);
    frame16x3(1, 1, 3, 16);
    flags("f2", 0, 0, 0);

    // 12-pixel line ends mid-word
    send_line(100, 12, 1, 1, 0, 3, 16, 0, 0);
    flags("pad", 1, 0, 0);

    // Third line longer than the first
    send_line(200, 16, 1, 1, 0, 1, 12, 0, 0);
    send_line(216, 16, 0, 1, 0, 0, 0, 0, 0);
    flags("len2", 0, 0, 0);
    send_line(232, 24, 0, 1, 0, 0, 0, 0, 0);
    flags("len3", 0, 1, 0);

    // sof arriving 5 pixels into line 1
    send_line(300, 8, 1, 1, 0, 3, 16, 0, 0);
    send_line(310, 5, 0, 0, 0, 0, 0, 0, 0);
    send_line(320, 8, 1, 1, 0, 1, 8, 1, 0);
    flags("sofmid", 0, 0, 1);

    // Reset three pixels into a word
    send_line(400, 3, 1, 0, 0, 1, 8, 0, 0);
    @(negedge clk);
    rst         = 1'b1;
    bus.pix_vld = 1'b0;
    bus.pix_sof = 1'b0;
    bus.pix_eol = 1'b0;
    @(posedge clk); #1;
    check("rst2_out_vld", bus.out_vld, 0);
    check("rst2_data_out", 32'(bus.data_out), 0);
    check("rst2_rows", rows, 2049);
    check("rst2_cols", cols, 2448);
    check("rst2_errs", {err_pad, err_len, err_sof}, 0);
    @(negedge clk);
    rst = 1'b0;
    send_line(500, 4, 0, 0, 0, 0, 0, 0, 0);
    send_line(600, 8, 1, 1, 0, 2049, 2448, 0, 0);
    flags("postrst", 0, 0, 0);

    // sof and eol on the same pixel
    send_line(700, 1, 1, 1, 0, 1, 8, 0, 1);
    idle(6);

    check("words_left", exp_q.size(), 0);
    check("word_count", n_words, n_exp);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
